// File: rtl/dcache_memory_responder_pkg.sv
// Shared types and default constants for the DCache memory-side responder.
package dcache_memory_responder_pkg;

  localparam int unsigned MEM_RESPONDER_LATENCY     = 8;
  localparam int unsigned MEM_RESPONDER_QUEUE_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } ResponderPhase;

  function automatic int unsigned maxWidth(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dcache_memory_responder_if.sv
// Line-request bus between the DCache miss path (master) and the memory responder (slave).
interface dcache_memory_responder_if #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned LINE_WIDTH    = 128,
  parameter int unsigned SERIAL_WIDTH  = 4,
  parameter int unsigned WSERIAL_WIDTH = 4
);

  logic                     memValid;
  logic                     memWE;
  logic [ADDR_WIDTH-1:0]    memAddr;
  logic [LINE_WIDTH-1:0]    memData;
  logic                     memReqAck;
  logic [SERIAL_WIDTH-1:0]  memSerial;
  logic [WSERIAL_WIDTH-1:0] memWSerial;
  logic                     memResultValid;
  logic [SERIAL_WIDTH-1:0]  memResultSerial;
  logic [LINE_WIDTH-1:0]    memResultData;
  logic                     memResponseValid;
  logic [WSERIAL_WIDTH-1:0] memResponseSerial;

  modport master (
    output memValid, memWE, memAddr, memData,
    input  memReqAck, memSerial, memWSerial,
    input  memResultValid, memResultSerial, memResultData,
    input  memResponseValid, memResponseSerial
  );

  modport slave (
    input  memValid, memWE, memAddr, memData,
    output memReqAck, memSerial, memWSerial,
    output memResultValid, memResultSerial, memResultData,
    output memResponseValid, memResponseSerial
  );

endinterface

// File: rtl/dcache_memory_responder_request_queue.sv
// In-order request FIFO with registered count and combinational head-entry read.
module dcache_memory_responder_request_queue #(
  parameter int unsigned Depth = 4,
  parameter type EntryT = logic [7:0],
  localparam int unsigned PtrWidth = $clog2(Depth),
  localparam int unsigned CountWidth = PtrWidth + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  EntryT                 pushEntry,
  input  logic                  pop,
  output EntryT                 headEntry,
  output logic                  full,
  output logic                  empty,
  output logic [CountWidth-1:0] count
);

  EntryT                 entries [Depth];
  logic [PtrWidth-1:0]   wrPtrQ;
  logic [PtrWidth-1:0]   rdPtrQ;
  logic [CountWidth-1:0] countQ;
  logic                  doPush;
  logic                  doPop;

  assign full      = (countQ == CountWidth'(Depth));
  assign empty     = (countQ == '0);
  assign count     = countQ;
  assign headEntry = entries[rdPtrQ];
  assign doPush    = push && !full;
  assign doPop     = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
      if (doPop)  rdPtrQ <= rdPtrQ + 1'b1;
      if (doPush && !doPop) begin
        countQ <= countQ + 1'b1;
      end else if (doPop && !doPush) begin
        countQ <= countQ - 1'b1;
      end
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (doPush) entries[wrPtrQ] <= pushEntry;
  end

endmodule

// File: rtl/dcache_memory_responder.sv
// Memory endpoint for DCache line requests: fixed-latency, strictly in-order, line-granular store.
module dcache_memory_responder
  import dcache_memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned LINE_WIDTH    = 128,
  parameter int unsigned SERIAL_WIDTH  = 4,
  parameter int unsigned WSERIAL_WIDTH = 4,
  parameter int unsigned QUEUE_DEPTH   = MEM_RESPONDER_QUEUE_DEPTH,
  parameter int unsigned LATENCY       = MEM_RESPONDER_LATENCY,
  parameter int unsigned MEM_LINE_NUM  = 1024
) (
  input logic clk,
  input logic rst,
  dcache_memory_responder_if.slave bus
);

  localparam int unsigned OffsetWidth    = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IndexWidth     = $clog2(MEM_LINE_NUM);
  localparam int unsigned SerialPadWidth = maxWidth(SERIAL_WIDTH, WSERIAL_WIDTH);
  localparam int unsigned CountWidth     = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned CdWidth        = $clog2(LATENCY);

  typedef struct packed {
    logic                      we;
    logic [IndexWidth-1:0]     index;
    logic [LINE_WIDTH-1:0]     data;
    logic [SerialPadWidth-1:0] serial;
  } ResponderEntry;

  ResponderEntry            pushEntry;
  ResponderEntry            headEntry;
  logic                     accept;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [CountWidth-1:0]    count;
  logic                     unusedAddr;

  logic [SERIAL_WIDTH-1:0]  rSerialQ;
  logic [WSERIAL_WIDTH-1:0] wSerialQ;

  ResponderPhase            phaseQ;
  logic [CdWidth-1:0]       countdownQ;
  logic                     enterResp;
  logic                     resultValidQ;
  logic [SERIAL_WIDTH-1:0]  resultSerialQ;
  logic [LINE_WIDTH-1:0]    resultDataQ;
  logic                     responseValidQ;
  logic [WSERIAL_WIDTH-1:0] responseSerialQ;

  logic [LINE_WIDTH-1:0]    lineMem [MEM_LINE_NUM];

  // Full is taken from the registered count, so a same-cycle retire never frees a slot.
  assign accept         = bus.memValid && !full;
  assign bus.memReqAck  = accept;
  assign bus.memSerial  = rSerialQ;
  assign bus.memWSerial = wSerialQ;
  assign unusedAddr     = ^bus.memAddr;

  always_comb begin
    pushEntry        = '0;
    pushEntry.we     = bus.memWE;
    pushEntry.index  = bus.memAddr[OffsetWidth +: IndexWidth];
    pushEntry.data   = bus.memData;
    pushEntry.serial = bus.memWE ? SerialPadWidth'(wSerialQ) : SerialPadWidth'(rSerialQ);
  end

  dcache_memory_responder_request_queue #(
    .Depth  (QUEUE_DEPTH),
    .EntryT (ResponderEntry)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pushEntry (pushEntry),
    .pop       (pop),
    .headEntry (headEntry),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rSerialQ <= '0;
      wSerialQ <= '0;
    end else if (accept) begin
      if (bus.memWE) begin
        wSerialQ <= wSerialQ + 1'b1;
      end else begin
        rSerialQ <= rSerialQ + 1'b1;
      end
    end
  end

  // IDLE and WAIT together span LATENCY-1 cycles, so the head hits RESP at accept+LATENCY.
  always_comb begin
    enterResp = 1'b0;
    if (phaseQ == IDLE) begin
      enterResp = !empty && (LATENCY == 2);
    end else if (phaseQ == WAIT) begin
      enterResp = (countdownQ <= CdWidth'(1));
    end
  end

  assign pop = (phaseQ == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      phaseQ          <= IDLE;
      countdownQ      <= '0;
      resultValidQ    <= 1'b0;
      resultSerialQ   <= '0;
      resultDataQ     <= '0;
      responseValidQ  <= 1'b0;
      responseSerialQ <= '0;
    end else begin
      resultValidQ   <= 1'b0;
      responseValidQ <= 1'b0;
      unique case (phaseQ)
        IDLE: begin
          if (!empty) begin
            phaseQ     <= enterResp ? RESP : WAIT;
            countdownQ <= CdWidth'(LATENCY - 2);
          end
        end
        WAIT: begin
          countdownQ <= countdownQ - 1'b1;
          if (enterResp) phaseQ <= RESP;
        end
        RESP:    phaseQ <= IDLE;
        default: phaseQ <= IDLE;
      endcase
      // Outputs are registered on the way into RESP so they are visible during RESP.
      if (enterResp) begin
        if (headEntry.we) begin
          responseValidQ  <= 1'b1;
          responseSerialQ <= headEntry.serial[WSERIAL_WIDTH-1:0];
        end else begin
          resultValidQ  <= 1'b1;
          resultSerialQ <= headEntry.serial[SERIAL_WIDTH-1:0];
          resultDataQ   <= lineMem[headEntry.index];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (phaseQ == RESP) && headEntry.we) begin
      lineMem[headEntry.index] <= headEntry.data;
    end
  end

  assign bus.memResultValid    = resultValidQ;
  assign bus.memResultSerial   = resultSerialQ;
  assign bus.memResultData     = resultDataQ;
  assign bus.memResponseValid  = responseValidQ;
  assign bus.memResponseSerial = responseSerialQ;

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (rst) bus.memValid |-> !$isunknown(bus.memWE));
  assert property (@(posedge clk) disable iff (rst) count <= CountWidth'(QUEUE_DEPTH));
  assert property (@(posedge clk) disable iff (rst) !(resultValidQ && responseValidQ));
`endif

endmodule

// File: doc/dcache_memory_responder.md
Name: dcache_memory_responder

Overview:
Memory-side endpoint of the DCache line-request protocol. It accepts line read/write requests issued by the DCache miss path (memValid/memWE/memAddr/memData) and returns a same-cycle acceptance with a serial number. After a fixed latency it returns the read result or write response, tagged with that serial. It backs requests with an internal line-granular memory and serves them strictly in order through a bounded request queue. Used as the main-memory model for cache-level simulation and as the on-chip memory responder in small FPGA builds.

Parameters:
ADDR_WIDTH, 32, physical address width (matches PhyAddrPath)
LINE_WIDTH, 128, line data width in bits (matches DCacheLinePath)
SERIAL_WIDTH, 4, read serial width (MemAccessSerial)
WSERIAL_WIDTH, 4, write serial width (MemWriteSerial)
QUEUE_DEPTH, 4, outstanding request capacity (power of 2, >=2)
LATENCY, 8, cycles from acceptance to result for an isolated request (>=2)
MEM_LINE_NUM, 1024, lines in backing memory (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
memValid  in  1  request valid
memWE  in  1  1 = line write, 0 = line read
memAddr  in  ADDR_WIDTH  byte address; offset bits ignored
memData  in  LINE_WIDTH  write line data
memReqAck  out  1  request accepted this cycle
memSerial  out  SERIAL_WIDTH  serial assigned to the read accepted this cycle
memWSerial  out  WSERIAL_WIDTH  serial assigned to the write accepted this cycle
memResultValid  out  1  read data valid (memAccessResult.valid)
memResultSerial  out  SERIAL_WIDTH  serial of returned read
memResultData  out  LINE_WIDTH  returned line
memResponseValid  out  1  write completed (memAccessResponse.valid)
memResponseSerial  out  WSERIAL_WIDTH  serial of completed write

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset: queue emptied, both serial counters = 0, head FSM = IDLE. memReqAck, memResultValid and memResponseValid = 0. Serial and data outputs = 0. Backing memory is not cleared.
- Accept rule: memReqAck = memValid && !full, combinational in the same cycle. full is derived from the registered count == QUEUE_DEPTH.
- When full, memReqAck = 0 even if the head retires in the same cycle. The requester must hold the request and retry.
- memSerial and memWSerial always show the current counter values, so they are valid in the ack cycle.
- On an accepted read, the read counter increments. On an accepted write, the write counter increments. Both wrap modulo 2^width. The counters are independent.
- Line index = memAddr[OFFSET +: log2(MEM_LINE_NUM)], where OFFSET = log2(LINE_WIDTH/8). Upper bits alias.
- Queue entry fields: we, index, data, serial (read or write as applicable). FIFO order; pointers wrap at QUEUE_DEPTH.
- Head FSM, IDLE:
  - When count != 0, load countdown = LATENCY-2 and go to WAIT.
  - An entry accepted in cycle T reaches IDLE evaluation at T+1.
- Head FSM, WAIT:
  - Decrement countdown each cycle.
  - When countdown == 0, go to RESP.
- Head FSM, RESP (exactly one cycle), then pop the head and return to IDLE:
  - Write: memory[index] <= data at the end of the cycle; memResponseValid = 1; memResponseSerial = serial.
  - Read: memResultValid = 1; memResultSerial = serial; memResultData = memory[index], read combinationally or pre-read in the last WAIT cycle.
- Latency: an isolated request accepted in cycle T produces its valid pulse in cycle T+LATENCY.
- Back-to-back requests complete one per LATENCY cycles: the next head enters IDLE the cycle after RESP.
- Valids are single-cycle pulses. No backpressure exists on results.
- Ordering: strictly in order across reads and writes. A read behind a write to the same line returns the written data.
- Simultaneous accept and pop (when not full): count is unchanged and both pointers advance.
- Reset mid-operation: in-flight requests are dropped with no result and no memory write. A write still in WAIT is lost.
- Result data outputs hold their last value when valid = 0.
- Assertions (simulation only):
  - no memValid with X on memWE;
  - count never exceeds QUEUE_DEPTH;
  - at most one of memResultValid / memResponseValid per cycle.

Decomposition:
- Shared package MemoryResponderTypes:
  - ResponderEntry struct (we, index, data, serial padded to max(SERIAL_WIDTH, WSERIAL_WIDTH));
  - ResponderPhase enum {IDLE, WAIT, RESP};
  - MEM_RESPONDER_LATENCY and MEM_RESPONDER_QUEUE_DEPTH constants.
- The protocol types (MemAccessSerial, MemWriteSerial, MemAccessResult, MemAccessResponse) remain in the existing cache-system types package and are reused by the wrapper.
- One natural sub-module: responder_request_queue. It is a parameterized FIFO with push/pop/full/empty/count and a head-entry read.

Test Plan:
- Reset then idle → all valids 0, memReqAck 0, memSerial 0, memWSerial 0 for 10 cycles.
- Write addr 0x0000_0040 data 0xA5…A5 at T=5, then read 0x40 at T=6 → ack both cycles, memWSerial 0 then memSerial 0. memResponseValid at T=13, serial 0. memResultValid at T=21, serial 0, data 0xA5…A5.
- Hold memValid on reads for 8 cycles with the queue draining slowly → 4 acks (serials 0–3), then memReqAck 0 until the first pop. The 5th read is acked the cycle after T+8 and gets serial 4.
- Issue 17 reads → serials 0…15, then 0 again (wrap). Results return in issue order with matching serials.
- Alias check: write line 0x0 and read 0x10000 with MEM_LINE_NUM=1024, LINE 16B → read returns the written data.
- Assert rst at LATENCY-3 cycles after accepting a write to 0x80 → no memResponseValid. A subsequent read of 0x80 returns the pre-write contents, and serials restart at 0.
